// File: rtl/alu_pkg.sv
// Shared opcode constants and pipeline records for the ALU issue/writeback stage.
// Opcode values mirror opcodes.vh; keep both in step.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_NEQ = 4'd8;
  localparam logic [3:0] OP_LT  = 4'd9;
  localparam logic [3:0] OP_LTE = 4'd10;
  localparam logic [3:0] OP_GT  = 4'd11;
  localparam logic [3:0] OP_GTE = 4'd12;

  // Register indices are carried at a fixed maximum width; users slice to AW.
  localparam int RIDX_W = 8;

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [RIDX_W-1:0] rd;
    logic [31:0]       a;
    logic [31:0]       b;
  } ex_stage_t;

  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic [31:0]       data;
    logic              over;
    logic              under;
  } result_t;

  function automatic logic uses_rs2(input logic [3:0] op);
    return op != OP_NOT;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 32 register file: two asynchronous read ports with r0 hard-wired to 0,
// one writeback port and one load port; writeback beats a load to the same index.
module alu_regfile #(
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [31:0]   rd_data1,
  output logic [31:0]   rd_data2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  logic [31:0] mem_reg [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_word
      localparam logic [AW-1:0] IDX = AW'(gi);
      // r0 never accepts a write, so it stays at its reset value of 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (gi != 0) begin
          if (wb_en && wb_addr == IDX) begin
            mem_reg[gi] <= wb_data;
          end else if (ld_en && ld_addr == IDX) begin
            mem_reg[gi] <= ld_data;
          end
        end
      end
    end
  endgenerate

  assign rd_data1 = (rd_addr1 == '0) ? 32'd0 : mem_reg[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? 32'd0 : mem_reg[rd_addr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/writeback controller around an external combinational ALU.
// Define ALU_FORWARD_EN to forward the EX result instead of stalling on RAW hazards.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int NREG = 8,
  parameter  int CNTW = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [31:0]     ld_data,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_sel,
  input  logic [31:0]     alu_out,
  input  logic            alu_over,
  input  logic            alu_under,
  output logic            res_valid,
  output logic [31:0]     res_data,
  output logic [AW-1:0]   res_rd,
  output logic            res_over,
  output logic            res_under,
  output logic            sticky_over,
  output logic            sticky_under,
  input  logic            clr_sticky,
  output logic [CNTW-1:0] instr_cnt
);

  logic            ready_reg;
  ex_stage_t       ex_reg, ex_next;
  result_t         res_reg, res_next;
  logic            res_valid_reg;
  logic            sticky_over_reg, sticky_over_next;
  logic            sticky_under_reg, sticky_under_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;

  logic [31:0]     rf_data1, rf_data2, op_a, op_b;
  logic [AW-1:0]   ex_rd;
  logic            haz_rs1, haz_rs2, hazard, accept;
  logic            unused_rd_bits;

  alu_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (in_rs1),
    .rd_addr2 (in_rs2),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2),
    .wb_en    (ex_reg.valid),
    .wb_addr  (ex_rd),
    .wb_data  (alu_out),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  assign ex_rd          = ex_reg.rd[AW-1:0];
  assign unused_rd_bits = ^{ex_reg.rd[RIDX_W-1:AW], res_reg.rd[RIDX_W-1:AW]};

  assign haz_rs1 = ex_reg.valid && (ex_rd != '0) && (in_rs1 == ex_rd);
  assign haz_rs2 = ex_reg.valid && (ex_rd != '0) && uses_rs2(in_op) && (in_rs2 == ex_rd);
  assign hazard  = haz_rs1 | haz_rs2;

`ifdef ALU_FORWARD_EN
  assign op_a     = haz_rs1 ? alu_out : rf_data1;
  assign op_b     = haz_rs2 ? alu_out : rf_data2;
  assign in_ready = ready_reg;
`else
  // One bubble lets the EX result land in the register file before the re-read.
  assign op_a     = rf_data1;
  assign op_b     = rf_data2;
  assign in_ready = ready_reg & ~hazard;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    ex_next       = ex_reg;
    ex_next.valid = accept;
    if (accept) begin
      ex_next.op = in_op;
      ex_next.rd = RIDX_W'(in_rd);
      ex_next.a  = op_a;
      ex_next.b  = uses_rs2(in_op) ? op_b : 32'd0;
    end

    res_next = res_reg;
    if (ex_reg.valid) begin
      res_next.rd    = ex_reg.rd;
      res_next.data  = alu_out;
      res_next.over  = alu_over;
      res_next.under = alu_under;
    end

    // A completing flag overrides a simultaneous clear.
    sticky_over_next  = (sticky_over_reg  & ~clr_sticky) | (ex_reg.valid & alu_over);
    sticky_under_next = (sticky_under_reg & ~clr_sticky) | (ex_reg.valid & alu_under);
    cnt_next          = cnt_reg + CNTW'(ex_reg.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg        <= 1'b0;
      ex_reg           <= '0;
      res_reg          <= '0;
      res_valid_reg    <= 1'b0;
      sticky_over_reg  <= 1'b0;
      sticky_under_reg <= 1'b0;
      cnt_reg          <= '0;
    end else begin
      ready_reg        <= 1'b1;
      ex_reg           <= ex_next;
      res_reg          <= res_next;
      res_valid_reg    <= ex_reg.valid;
      sticky_over_reg  <= sticky_over_next;
      sticky_under_reg <= sticky_under_next;
      cnt_reg          <= cnt_next;
    end
  end

  assign alu_a        = ex_reg.a;
  assign alu_b        = ex_reg.b;
  assign alu_sel      = ex_reg.op;
  assign res_valid    = res_valid_reg;
  assign res_data     = res_reg.data;
  assign res_rd       = res_reg.rd[AW-1:0];
  assign res_over     = res_reg.over;
  assign res_under    = res_reg.under;
  assign sticky_over  = sticky_over_reg;
  assign sticky_under = sticky_under_reg;
  assign instr_cnt    = cnt_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model closing the loop.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic [3:0]      in_op = '0;
  logic [AW-1:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic            ld_en = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [31:0]     ld_data = '0;
  logic [31:0]     alu_a, alu_b, alu_out;
  logic [3:0]      alu_sel;
  logic            alu_over, alu_under;
  logic            res_valid, res_over, res_under;
  logic [31:0]     res_data;
  logic [AW-1:0]   res_rd;
  logic            sticky_over, sticky_under;
  logic            clr_sticky = 1'b0;
  logic [CNTW-1:0] instr_cnt;

  alu_issue_ctrl #(.NREG(NREG), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_over(alu_over), .alu_under(alu_under),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .res_over(res_over), .res_under(res_under),
    .sticky_over(sticky_over), .sticky_under(sticky_under),
    .clr_sticky(clr_sticky), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: signed compares, signed overflow split into over/under.
  logic [31:0] sum, dif;
  logic [63:0] prod;
  always_comb begin
    sum       = alu_a + alu_b;
    dif       = alu_a - alu_b;
    prod      = $signed(alu_a) * $signed(alu_b);
    alu_out   = 32'd0;
    alu_over  = 1'b0;
    alu_under = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_out   = sum;
        alu_over  = !alu_a[31] && !alu_b[31] &&  sum[31];
        alu_under =  alu_a[31] &&  alu_b[31] && !sum[31];
      end
      OP_SUB: begin
        alu_out   = dif;
        alu_over  = !alu_a[31] &&  alu_b[31] &&  dif[31];
        alu_under =  alu_a[31] && !alu_b[31] && !dif[31];
      end
      OP_MUL: begin
        alu_out   = prod[31:0];
        alu_over  = (prod[63:31] != '0) && !prod[63];
        alu_under = (prod[63:31] != '1) &&  prod[63];
      end
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_NOT: alu_out = ~alu_a;
      OP_EQ:  alu_out = {31'd0, alu_a == alu_b};
      OP_NEQ: alu_out = {31'd0, alu_a != alu_b};
      OP_LT:  alu_out = {31'd0, $signed(alu_a) <  $signed(alu_b)};
      OP_LTE: alu_out = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      OP_GT:  alu_out = {31'd0, $signed(alu_a) >  $signed(alu_b)};
      OP_GTE: alu_out = {31'd0, $signed(alu_a) >= $signed(alu_b)};
      default: alu_out = 32'd0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = idx; ld_data = val;
    @(negedge clk);
    ld_en = 1'b0;
    $display("load r%0d=%h", idx, val);
  endtask

  // Returns at 1 ns after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [31:0] exp, input logic ov, input logic un);
    issue(op, rd, rs1, rs2);
    @(negedge clk);
    check({name, "_sel"}, {28'd0, alu_sel}, {28'd0, op});
    check({name, "_early"}, {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 16;
    check({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({name, "_data"}, res_data, exp);
    check({name, "_rd"}, {29'd0, res_rd}, {29'd0, rd});
    check({name, "_flags"}, {30'd0, res_over, res_under}, {30'd0, ov, un});
    check({name, "_cnt"}, {28'd0, instr_cnt}, exp_cnt);
    $display("op %s rd=r%0d data=%h over=%b under=%b cnt=%0d", name, res_rd, res_data,
             res_over, res_under, instr_cnt);
  endtask

  typedef struct {
    string         name;
    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int stalls;
    bit found;
    logic [31:0] got;

    // r1=1, r2=2 loaded below; r3 is produced by the first vector.
    vecs[0]  = '{"add",   OP_ADD, 3'd3, 3'd1, 3'd2, 32'd3};
    vecs[1]  = '{"sub",   OP_SUB, 3'd5, 3'd2, 3'd1, 32'd1};
    vecs[2]  = '{"mul",   OP_MUL, 3'd6, 3'd2, 3'd3, 32'd6};
    vecs[3]  = '{"and",   OP_AND, 3'd7, 3'd1, 3'd3, 32'd1};
    vecs[4]  = '{"or",    OP_OR,  3'd7, 3'd1, 3'd2, 32'd3};
    vecs[5]  = '{"xor",   OP_XOR, 3'd7, 3'd3, 3'd1, 32'd2};
    vecs[6]  = '{"not",   OP_NOT, 3'd7, 3'd1, 3'd2, 32'hFFFF_FFFE};
    vecs[7]  = '{"eq_r0", OP_EQ,  3'd0, 3'd1, 3'd1, 32'd1};
    vecs[8]  = '{"neq",   OP_NEQ, 3'd7, 3'd1, 3'd2, 32'd1};
    vecs[9]  = '{"lt",    OP_LT,  3'd7, 3'd1, 3'd2, 32'd1};
    vecs[10] = '{"lte",   OP_LTE, 3'd7, 3'd2, 3'd1, 32'd0};
    vecs[11] = '{"gt",    OP_GT,  3'd7, 3'd2, 3'd1, 32'd1};
    vecs[12] = '{"gte",   OP_GTE, 3'd7, 3'd1, 3'd1, 32'd1};
    vecs[13] = '{"r0_rd", OP_ADD, 3'd7, 3'd0, 3'd1, 32'd1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1 check("ready_at_release", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, in_ready}, 32'd1);
    check("rst_alu", {alu_a | alu_b}, 32'd0);
    check("rst_sel", {28'd0, alu_sel}, 32'd0);
    check("rst_res", {res_data[31:5], res_valid, res_over, res_under, sticky_over, sticky_under},
          32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_cnt", {28'd0, instr_cnt}, 32'd0);

    load(3'd1, 32'd1);
    load(3'd2, 32'd2);
    load(3'd0, 32'h0000_DEAD);
    run_op("r0_after_load", OP_ADD, 3'd7, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].exp,
             1'b0, 1'b0);

    // Overflow and sticky behaviour.
    load(3'd6, 32'h7FFF_FFFF);
    run_op("add_ovf", OP_ADD, 3'd4, 3'd6, 3'd1, 32'h8000_0000, 1'b1, 1'b0);
    check("sticky_over_set", {31'd0, sticky_over}, 32'd1);
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    check("sticky_over_clr", {31'd0, sticky_over}, 32'd0);
    load(3'd5, 32'h8000_0000);
    load(3'd6, 32'hFFFF_FFFF);
    run_op("add_unf", OP_ADD, 3'd4, 3'd5, 3'd6, 32'h7FFF_FFFF, 1'b0, 1'b1);
    check("sticky_under_set", {31'd0, sticky_under}, 32'd1);

    // Dependent chain; stale r3=100 would give 99 if the hazard were missed.
    load(3'd3, 32'd100);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ADD; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
    check("chain_first_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_op = OP_SUB; in_rd = 3'd5; in_rs1 = 3'd3; in_rs2 = 3'd1;
    stalls = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (in_ready) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef ALU_FORWARD_EN
    check("chain_stalls", stalls, 32'd0);
`else
    check("chain_stalls", stalls, 32'd1);
`endif
    found = 1'b0; got = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid && res_rd == 3'd5) begin found = 1'b1; got = res_data; end
    end
    exp_cnt = (exp_cnt + 2) % 16;
    check("chain_found", {31'd0, found}, 32'd1);
    check("chain_data", got, 32'd2);
    $display("chain sub r5 data=%h stalls=%0d", got, stalls);

    // Writeback r6=2+3 collides with a load of 9 on the same edge.
    issue(OP_ADD, 3'd6, 3'd2, 3'd3);
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'd9;
    @(posedge clk);
    #1 ld_en = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    run_op("collision", OP_ADD, 3'd7, 3'd6, 3'd0, 32'd5, 1'b0, 1'b0);

    // Reset while a MUL sits in EX.
    issue(OP_MUL, 3'd7, 3'd2, 3'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_cnt", {28'd0, instr_cnt}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_result", {31'd0, res_valid}, 32'd0);
    exp_cnt = 0;
    run_op("rf_cleared", OP_ADD, 3'd7, 3'd1, 3'd2, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      run_op("wrap", OP_ADD, 3'd7, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
    check("cnt_wrapped", {28'd0, instr_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/writeback stage that sits directly upstream of the combinational `alu` and consumes its results. It accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `input1`/`input2`/`alu_sel` from a registered execute stage, writes the ALU result back, and accumulates sticky overflow/underflow status and a completed-instruction count.

## Interface
- `NREG`, 8: number of 32-bit registers; a power of 2; `AW = $clog2(NREG)`.
- `CNTW`, 16: width of the completed-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: stage can accept; transfer occurs when `in_valid & in_ready`.
- `in_op` in 4: ALU opcode from `opcodes.vh` (ADD, SUB, MUL, AND, OR, XOR, NOT, EQ, NEQ, LT, LTE, GT, GTE).
- `in_rd`, `in_rs1`, `in_rs2` in AW each: destination and source register indices.
- `ld_en` in 1: direct register load.
- `ld_addr` in AW: register index for the load.
- `ld_data` in 32: value for the load.
- `alu_a`, `alu_b` out 32: drive ALU `input1`/`input2`.
- `alu_sel` out 4: drives ALU `alu_sel`.
- `alu_out` in 32: ALU result.
- `alu_over`, `alu_under` in 1: ALU overflow/underflow flags.
- `res_valid` out 1: one-cycle pulse per completed instruction.
- `res_data` out 32: result value of the completed instruction.
- `res_rd` out AW: destination index of the completed instruction.
- `res_over`, `res_under` out 1: flags of the completed instruction.
- `sticky_over`, `sticky_under` out 1: OR of all flags since the last clear.
- `clr_sticky` in 1: clears the sticky flags.
- `instr_cnt` out CNTW: number of completed instructions, wrapping.

## Operation
- Two stages.
  - ISSUE: accept the instruction, read `rs1`/`rs2`, and register them into EX.
  - EX: registered `alu_a`/`alu_b`/`alu_sel`; the ALU evaluates combinationally; the result is captured into the writeback registers and the register file on the closing edge of the EX cycle.
- Register 0 always reads 0.
  - Writes to r0 from a result or a load are discarded.
  - A result targeting r0 still produces `res_valid` and still updates the sticky flags and the counter.
- NOT ignores `rs2`; `alu_b` is driven with 0 for NOT.
- Compare ops write the ALU output (0 or 1) to `rd` unmodified.
- EX holds a valid bit. When EX is empty, `alu_sel`/`alu_a`/`alu_b` hold their last values, and no writeback or flag update occurs.
- RAW hazard condition:
  - an incoming `rs1`, or `rs2` on any op other than NOT, equals the EX-stage `rd`;
  - EX is valid; and
  - that `rd` is not r0.
- Write-through: a register-file write at edge E is visible to a read in the cycle after E.
- `ld_en` writes `ld_data` at the next edge.
  - If a writeback targets the same index on the same edge, the writeback wins and the load is dropped.
  - A load to an index read by an issuing instruction in the same cycle is not forwarded; the read returns the old value.
- Sticky flags set on any completion with the corresponding flag high.
  - `clr_sticky` clears them on the next edge.
  - A completion with a flag high in the same cycle as `clr_sticky` wins: the sticky flag ends at 1.
- `instr_cnt` increments by 1 per completion and wraps from 2^CNTW−1 to 0.

## Timing
- Reset values:
  - `in_ready` 0 while `rst_n` is low, then 1 from the first cycle after deassertion unless stalled.
  - `alu_a`/`alu_b` 0; `alu_sel` 0.
  - `res_*` 0; sticky flags 0; `instr_cnt` 0.
  - All registers 0; EX invalid.
- Latency: accepted at edge N, so `alu_*` are valid in cycle N+1, and `res_valid`=1 with `res_data`/`res_rd`/`res_*` valid in cycle N+2.
- Throughput: one instruction per cycle when there are no stalls.
- No backpressure on results: `res_valid` is a pulse and must be sampled by the consumer.
- Asserting `rst_n` low mid-operation discards the in-flight EX instruction immediately. No `res_valid` is produced for it, and the register file clears.

## Configuration
- `ALU_FORWARD_EN` defined:
  - On a RAW hazard the operand mux selects `alu_out` (the EX result) in place of the register-file value.
  - `in_ready` stays 1 and back-to-back dependent instructions issue every cycle.
- `ALU_FORWARD_EN` undefined:
  - On a RAW hazard `in_ready` deasserts for exactly one cycle (one bubble: EX invalid in the following cycle).
  - The instruction then reads the written-through value.

## Structure
- Shared package `alu_pkg`:
  - opcode constants, which mirror `opcodes.vh` and do not redefine it;
  - the EX-stage struct {valid, op, rd, a, b};
  - the result struct {rd, data, over, under}.
- One sub-module, `alu_regfile`:
  - NREG×32 storage;
  - two asynchronous read ports with r0 forced to 0;
  - one write port with writeback-over-load priority.
- The hazard detection and forwarding mux live in the top module.

## Test plan
- Reset and load:
  - Hold `rst_n` low, then release: all outputs are 0 and `in_ready` rises in the cycle after release.
  - Load r1=1, r2=2, then issue ADD r3=r1+r2: `res_valid` two cycles after accept, `res_data`=3, `res_rd`=3.
- Overflow:
  - r1=0x7FFFFFFF, r2=1, ADD r4: `res_over`=1 and `sticky_over`=1.
  - Then `clr_sticky` with no completion: `sticky_over`=0.
- Dependent chain: ADD r3=r1+r2 followed immediately by SUB r5=r3−r1 (r1=1, r2=2), giving `res_data`=2.
  - With `ALU_FORWARD_EN`: no stall.
  - Without it: `in_ready` is low for exactly one cycle.
- r0 handling:
  - Load r0=0xDEAD: r0 still reads 0.
  - EQ r0=r1,r1: `res_valid`=1, `res_data`=1, r0 unchanged.
- Collision: a writeback to r6=5 and `ld_en` r6=9 on the same edge leave r6=5.
- Reset mid-operation:
  - Issue MUL, then pull `rst_n` low the next cycle: no `res_valid`, `instr_cnt`=0.
  - With CNTW=4, sixteen completions: `instr_cnt` wraps to 0.
